bp_resolve: RTL and testbench

- Resolution-side partner of the fetch-stage branch predictor.
- Queues each prediction made at fetch in an in-order FIFO. Checks it against the outcome resolved in execute.
- On a mismatch, raises a redirect/flush.
- Drives the registered training interface the predictor consumes: need-predict strobe, actual jump, branch address.
- Keeps saturating branch and mispredict counters for performance analysis.

---
 rtl/bp_resolve.sv | 131 +++++++++++++
 tb/tb_bp_resolve.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve.sv
// Branch resolution: queues fetch-time predictions, checks them against execute,
// raises redirects and drives the predictor's registered training interface.
module bp_resolve #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int CW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid_i,
    input  logic [AW-1:0]              pred_pc_i,
    input  logic                       pred_taken_i,
    input  logic [AW-1:0]              pred_target_i,
    output logic                       pred_ready_o,
    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    input  logic [AW-1:0]              res_target_i,
    input  logic                       flush_i,
    output logic                       redirect_o,
    output logic [AW-1:0]              redirect_addr_o,
    output logic                       last_need_predict_o,
    output logic                       last_jump_o,
    output logic [AW-1:0]              last_addr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CW-1:0]              branch_cnt_o,
    output logic [CW-1:0]              mispred_cnt_o,
    output logic                       err_o
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] pc_mem [DEPTH];
    logic [AW-1:0] tg_mem [DEPTH];
    logic          tk_mem [DEPTH];

    logic [PW:0]   wptr;
    logic [PW:0]   rptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          mispred;
    logic          clear;
    logic [AW-1:0] head_pc;
    logic [AW-1:0] head_tg;
    logic          head_tk;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] mcnt;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign empty = (wptr == rptr);

    assign head_pc = pc_mem[rptr[PW-1:0]];
    assign head_tg = tg_mem[rptr[PW-1:0]];
    assign head_tk = tk_mem[rptr[PW-1:0]];

    assign pred_ready_o = !full;
    assign push         = pred_valid_i && !full;
    assign pop          = res_valid_i && !empty;

    assign mispred = (head_tk != res_taken_i) ||
                     (head_tk && res_taken_i && (head_tg != res_target_i));

    assign redirect_o = pop && mispred;
    assign clear      = redirect_o || flush_i;

    always_comb begin
        redirect_addr_o = '0;
        if (redirect_o)
            redirect_addr_o = res_taken_i ? res_target_i : head_pc + AW'(4);
    end

    assign count_o       = wptr - rptr;
    assign branch_cnt_o  = bcnt;
    assign mispred_cnt_o = mcnt;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr[PW-1:0]] <= pred_pc_i;
            tg_mem[wptr[PW-1:0]] <= pred_target_i;
            tk_mem[wptr[PW-1:0]] <= pred_taken_i;
        end
    end

    // A mispredict or flush drops everything queued, including a same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_need_predict_o <= 1'b0;
            last_jump_o         <= 1'b0;
            last_addr_o         <= '0;
        end else begin
            last_need_predict_o <= pop;
            if (pop) begin
                last_jump_o <= res_taken_i;
                last_addr_o <= head_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt  <= '0;
            mcnt  <= '0;
            err_o <= 1'b0;
        end else begin
            if (pop && (bcnt != {CW{1'b1}}))
                bcnt <= bcnt + 1'b1;
            if (redirect_o && (mcnt != {CW{1'b1}}))
                mcnt <= mcnt + 1'b1;
            if (res_valid_i && empty)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_resolve.sv
// Scoreboard bench for bp_resolve: predictions are queued in the bench model
// on push and popped against each resolve to form expected outputs.
module tb_bp_resolve;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        pred_valid_i;
    logic [31:0] pred_pc_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic        pred_ready_o;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        flush_i;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        last_need_predict_o;
    logic        last_jump_o;
    logic [31:0] last_addr_o;
    logic [2:0]  count_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;
    logic        err_o;

    bp_resolve #(.DEPTH(DEPTH), .AW(32), .CW(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pred_valid_i        (pred_valid_i),
        .pred_pc_i           (pred_pc_i),
        .pred_taken_i        (pred_taken_i),
        .pred_target_i       (pred_target_i),
        .pred_ready_o        (pred_ready_o),
        .res_valid_i         (res_valid_i),
        .res_taken_i         (res_taken_i),
        .res_target_i        (res_target_i),
        .flush_i             (flush_i),
        .redirect_o          (redirect_o),
        .redirect_addr_o     (redirect_addr_o),
        .last_need_predict_o (last_need_predict_o),
        .last_jump_o         (last_jump_o),
        .last_addr_o         (last_addr_o),
        .count_o             (count_o),
        .branch_cnt_o        (branch_cnt_o),
        .mispred_cnt_o       (mispred_cnt_o),
        .err_o               (err_o)
    );

    int tot = 0;
    int bad = 0;

    ent_t        sb[$];
    logic [31:0] mb;
    logic [31:0] mm;
    logic        merr;
    logic        mln;
    logic        mlj;
    logic [31:0] mla;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus and advance the model to its post-edge state.
    task automatic cyc(
        input  logic        pv,
        input  logic [31:0] pc,
        input  logic        ptk,
        input  logic [31:0] ptg,
        input  logic        rv,
        input  logic        rtk,
        input  logic [31:0] rtg,
        input  logic        fl,
        output logic        e_redir,
        output logic [31:0] e_addr,
        output logic        e_ready
    );
        ent_t h;
        ent_t n;
        logic acc;
        logic popm;
        pred_valid_i  = pv;
        pred_pc_i     = pc;
        pred_taken_i  = ptk;
        pred_target_i = ptg;
        res_valid_i   = rv;
        res_taken_i   = rtk;
        res_target_i  = rtg;
        flush_i       = fl;
        #1;
        e_ready = (sb.size() < DEPTH);
        acc     = pv && e_ready;
        popm    = rv && (sb.size() > 0);
        e_redir = 1'b0;
        e_addr  = 32'h0;
        if (rv && !popm)
            merr = 1'b1;
        mln = popm;
        if (popm) begin
            h = sb.pop_front();
            e_redir = (h.tk != rtk) || (h.tk && rtk && h.tg != rtg);
            if (e_redir)
                e_addr = rtk ? rtg : h.pc + 32'd4;
            mlj = rtk;
            mla = h.pc;
            if (mb != 32'hFFFF_FFFF)
                mb = mb + 1;
            if (e_redir && mm != 32'hFFFF_FFFF)
                mm = mm + 1;
        end
        if (e_redir || fl) begin
            sb.delete();
        end else if (acc) begin
            n.pc = pc;
            n.tk = ptk;
            n.tg = ptg;
            sb.push_back(n);
        end
    endtask

    task automatic idle_inputs();
        pred_valid_i  = 1'b0;
        pred_pc_i     = 32'h0;
        pred_taken_i  = 1'b0;
        pred_target_i = 32'h0;
        res_valid_i   = 1'b0;
        res_taken_i   = 1'b0;
        res_target_i  = 32'h0;
        flush_i       = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        mb   = 32'h0;
        mm   = 32'h0;
        merr = 1'b0;
        mln  = 1'b0;
        mlj  = 1'b0;
        mla  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        tot++;
        if (count_o !== 3'd0 || pred_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_q got cnt=%0d rdy=%0b exp cnt=0 rdy=1", count_o, pred_ready_o);
        end
        tot++;
        if (last_need_predict_o !== 1'b0 || last_jump_o !== 1'b0 || last_addr_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_train got %0b %0b %h exp 0 0 0",
                     last_need_predict_o, last_jump_o, last_addr_o);
        end
        tot++;
        if (branch_cnt_o !== 32'h0 || mispred_cnt_o !== 32'h0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_cnt got b=%0d m=%0d e=%0b exp 0 0 0",
                     branch_cnt_o, mispred_cnt_o, err_o);
        end
        tot++;
        if (redirect_o !== 1'b0 || redirect_addr_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_redir got %0b %h exp 0 0", redirect_o, redirect_addr_o);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_correct();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(1, 32'h100, 0, 32'h200, 0, 0, 0, 0, er, ea, ey);
        tot++;
        if (pred_ready_o !== ey) begin
            bad++;
            $display("FAIL corr_ready got %0b exp %0b", pred_ready_o, ey);
        end
        tick();
        cyc(0, 0, 0, 0, 1, 0, 0, 0, er, ea, ey);
        tot++;
        if (redirect_o !== er) begin
            bad++;
            $display("FAIL corr_redir got %0b exp %0b", redirect_o, er);
        end
        tick();
        tot++;
        if (last_need_predict_o !== mln || last_jump_o !== mlj || last_addr_o !== mla) begin
            bad++;
            $display("FAIL corr_train got %0b %0b %h exp %0b %0b %h",
                     last_need_predict_o, last_jump_o, last_addr_o, mln, mlj, mla);
        end
        tot++;
        if (branch_cnt_o !== mb || mispred_cnt_o !== mm) begin
            bad++;
            $display("FAIL corr_cnt got b=%0d m=%0d exp b=%0d m=%0d",
                     branch_cnt_o, mispred_cnt_o, mb, mm);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, er, ea, ey);
        tick();
        tot++;
        if (last_need_predict_o !== 1'b0 || last_addr_o !== mla) begin
            bad++;
            $display("FAIL corr_hold got %0b %h exp 0 %h",
                     last_need_predict_o, last_addr_o, mla);
        end
    endtask

    task automatic test_mispred_dir();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(1, 32'h200, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(0, 0, 0, 0, 1, 1, 32'h180, 0, er, ea, ey);
        tot++;
        if (redirect_o !== er || redirect_addr_o !== ea) begin
            bad++;
            $display("FAIL dir_redir got %0b %h exp %0b %h",
                     redirect_o, redirect_addr_o, er, ea);
        end
        tick();
        tot++;
        if (count_o !== 3'(sb.size()) || mispred_cnt_o !== mm || last_jump_o !== mlj) begin
            bad++;
            $display("FAIL dir_after got c=%0d m=%0d j=%0b exp c=%0d m=%0d j=%0b",
                     count_o, mispred_cnt_o, last_jump_o, sb.size(), mm, mlj);
        end
    endtask

    task automatic test_mispred_target();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(1, 32'h300, 1, 32'h340, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(0, 0, 0, 0, 1, 0, 32'h0, 0, er, ea, ey);
        tot++;
        if (redirect_o !== er || redirect_addr_o !== ea) begin
            bad++;
            $display("FAIL nt_redir got %0b %h exp %0b %h",
                     redirect_o, redirect_addr_o, er, ea);
        end
        tick();
        cyc(1, 32'h300, 1, 32'h340, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h400, 1, 32'h440, 0, 0, 0, 0, er, ea, ey);
        tick();
        // Mispredict on the target while a wrong-path push arrives.
        cyc(1, 32'h500, 0, 32'h0, 1, 1, 32'h344, 0, er, ea, ey);
        tot++;
        if (redirect_o !== er || redirect_addr_o !== ea) begin
            bad++;
            $display("FAIL tg_redir got %0b %h exp %0b %h",
                     redirect_o, redirect_addr_o, er, ea);
        end
        tick();
        tot++;
        if (count_o !== 3'(sb.size()) || mispred_cnt_o !== mm) begin
            bad++;
            $display("FAIL tg_clear got c=%0d m=%0d exp c=%0d m=%0d",
                     count_o, mispred_cnt_o, sb.size(), mm);
        end
    endtask

    task automatic test_full_wrap();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(1, 32'h40, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(0, 0, 0, 0, 1, 0, 0, 0, er, ea, ey);
        tick();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h1000 + 32'(i * 16), 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
            tot++;
            if (pred_ready_o !== ey) begin
                bad++;
                $display("FAIL full_ready%0d got %0b exp %0b", i, pred_ready_o, ey);
            end
            tick();
        end
        tot++;
        if (count_o !== 3'(sb.size())) begin
            bad++;
            $display("FAIL full_count got %0d exp %0d", count_o, sb.size());
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 0, er, ea, ey);
            tick();
            tot++;
            if (last_need_predict_o !== mln || last_addr_o !== mla || redirect_o !== 1'b0) begin
                bad++;
                $display("FAIL drain%0d got %0b %h exp %0b %h",
                         i, last_need_predict_o, last_addr_o, mln, mla);
            end
        end
        tot++;
        if (count_o !== 3'd0 || pred_ready_o !== 1'b1 || branch_cnt_o !== mb) begin
            bad++;
            $display("FAIL drain_end got c=%0d r=%0b b=%0d exp c=0 r=1 b=%0d",
                     count_o, pred_ready_o, branch_cnt_o, mb);
        end
    endtask

    task automatic test_back_to_back();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(1, 32'h2000, 1, 32'h2100, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h2004, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h2008, 0, 32'h0, 1, 1, 32'h2100, 0, er, ea, ey);
        tick();
        tot++;
        if (count_o !== 3'(sb.size()) || last_addr_o !== mla) begin
            bad++;
            $display("FAIL b2b_cnt got c=%0d a=%h exp c=%0d a=%h",
                     count_o, last_addr_o, sb.size(), mla);
        end
        cyc(1, 32'h200C, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h2010, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h2014, 0, 32'h0, 1, 0, 0, 0, er, ea, ey);
        tot++;
        if (pred_ready_o !== ey) begin
            bad++;
            $display("FAIL b2b_full_rdy got %0b exp %0b", pred_ready_o, ey);
        end
        tick();
        tot++;
        if (count_o !== 3'(sb.size())) begin
            bad++;
            $display("FAIL b2b_full_cnt got %0d exp %0d", count_o, sb.size());
        end
        while (sb.size() > 0) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 0, er, ea, ey);
            tick();
            tot++;
            if (last_addr_o !== mla || last_need_predict_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b_drain got %h %0b exp %h 1",
                         last_addr_o, last_need_predict_o, mla);
            end
        end
    endtask

    task automatic test_flush();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(1, 32'h3000, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h3004, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h3008, 0, 32'h0, 1, 0, 0, 1, er, ea, ey);
        tot++;
        if (redirect_o !== er) begin
            bad++;
            $display("FAIL flush_redir got %0b exp %0b", redirect_o, er);
        end
        tick();
        tot++;
        if (count_o !== 3'(sb.size()) || last_need_predict_o !== mln ||
            last_addr_o !== mla || branch_cnt_o !== mb) begin
            bad++;
            $display("FAIL flush_after got c=%0d n=%0b a=%h b=%0d exp c=%0d n=%0b a=%h b=%0d",
                     count_o, last_need_predict_o, last_addr_o, branch_cnt_o,
                     sb.size(), mln, mla, mb);
        end
    endtask

    task automatic test_empty_err();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(0, 0, 0, 0, 1, 1, 32'h9000, 0, er, ea, ey);
        tot++;
        if (redirect_o !== 1'b0) begin
            bad++;
            $display("FAIL empty_redir got %0b exp 0", redirect_o);
        end
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, er, ea, ey);
        tot++;
        if (err_o !== merr || last_need_predict_o !== 1'b0 ||
            branch_cnt_o !== mb || mispred_cnt_o !== mm) begin
            bad++;
            $display("FAIL empty_err got e=%0b n=%0b b=%0d m=%0d exp e=%0b n=0 b=%0d m=%0d",
                     err_o, last_need_predict_o, branch_cnt_o, mispred_cnt_o, merr, mb, mm);
        end
        tick();
        tick();
        tot++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got %0b exp 1", err_o);
        end
    endtask

    task automatic test_saturate();
        logic er;
        logic [31:0] ea;
        logic ey;
        force dut.bcnt = 32'hFFFF_FFFF;
        #1;
        release dut.bcnt;
        mb = 32'hFFFF_FFFF;
        cyc(1, 32'h4000, 0, 32'h0, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(0, 0, 0, 0, 1, 0, 0, 0, er, ea, ey);
        tick();
        tot++;
        if (branch_cnt_o !== 32'hFFFF_FFFF || last_need_predict_o !== 1'b1) begin
            bad++;
            $display("FAIL sat_branch got %h n=%0b exp ffffffff n=1",
                     branch_cnt_o, last_need_predict_o);
        end
    endtask

    task automatic test_async_reset();
        logic er;
        logic [31:0] ea;
        logic ey;
        cyc(1, 32'h5000, 1, 32'h5100, 0, 0, 0, 0, er, ea, ey);
        tick();
        cyc(1, 32'h5004, 0, 32'h0, 1, 1, 32'h5100, 0, er, ea, ey);
        tick();
        idle_inputs();
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        tot++;
        if (count_o !== 3'd0 || pred_ready_o !== 1'b1 || err_o !== 1'b0 ||
            branch_cnt_o !== 32'h0 || mispred_cnt_o !== 32'h0) begin
            bad++;
            $display("FAIL arst_q got c=%0d r=%0b e=%0b b=%0d m=%0d exp 0 1 0 0 0",
                     count_o, pred_ready_o, err_o, branch_cnt_o, mispred_cnt_o);
        end
        tot++;
        if (last_need_predict_o !== 1'b0 || last_addr_o !== 32'h0 || last_jump_o !== 1'b0) begin
            bad++;
            $display("FAIL arst_train got %0b %h %0b exp 0 0 0",
                     last_need_predict_o, last_addr_o, last_jump_o);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        tot++;
        if (last_need_predict_o !== 1'b0 || count_o !== 3'd0) begin
            bad++;
            $display("FAIL arst_after got n=%0b c=%0d exp 0 0",
                     last_need_predict_o, count_o);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_mispred_dir();
        test_mispred_target();
        test_full_wrap();
        test_back_to_back();
        test_flush();
        test_empty_err();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
